bk_limb_add_ctrl: RTL and testbench
===================================

BK_LIMB_ADD_CTRL -- requirements
Module: bk_limb_add_ctrl

Interface
REQ-001 The block SHALL have parameter LIMB_W, default 12, the limb width; only 12 is supported, matching the 12-bit adder stage it drives.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand limb available.
REQ-005 in_ready  output  1  block accepts a limb this cycle.
REQ-006 in_a  input  12  operand A limb.
REQ-007 in_b  input  12  operand B limb.
REQ-008 in_last  input  1  marks the most-significant limb of a multi-limb addition.
REQ-009 add_ins  output  24  drives the adder INPUTS bus.
REQ-010 add_outs  input  13  adder OUTS bus (combinational result of add_ins).
REQ-011 out_valid  output  1  result limb available.
REQ-012 out_ready  input  1  consumer accepts the result limb.
REQ-013 out_sum  output  12  result limb.
REQ-014 out_carry  output  1  carry out of this limb.
REQ-015 out_last  output  1  copy of in_last for this limb.

Function
REQ-016 add_ins SHALL be interleaved: add_ins[2i]=X[i], add_ins[2i+1]=Y[i], for i=0..11.
REQ-017 The FSM SHALL have exactly four states: IDLE, P1, P2, OUT.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in other states.
REQ-019 In IDLE, an in_valid&&in_ready edge SHALL register in_a, in_b and in_last into op_a, op_b and last_r, then go to P1.
REQ-020 In IDLE and OUT, add_ins SHALL be 24'h000000.
REQ-021 In P1, X=op_a and Y=op_b; the edge SHALL capture add_outs into sum_r[12:0].
REQ-022 P1 SHALL go to P2 if cin_r=1, else to OUT.
REQ-023 In P2, X=sum_r[11:0] and Y=12'h001; the edge SHALL set sum_r[11:0]<=add_outs[11:0] and sum_r[12]<=sum_r[12]|add_outs[12]; then go to OUT.
REQ-024 In OUT, out_valid=1, out_sum=sum_r[11:0], out_carry=sum_r[12], out_last=last_r.
REQ-025 out_sum, out_carry and out_last SHALL be 0 whenever out_valid=0.
REQ-026 In OUT, outputs SHALL hold stable while out_ready=0.
REQ-027 An OUT edge with out_ready=1 SHALL set cin_r<=(last_r ? 0 : sum_r[12]) and return to IDLE.
REQ-028 Latency SHALL be: out_valid asserted 2 cycles after the accept edge when cin_r=0, 3 cycles when cin_r=1.
REQ-029 Throughput: the next limb SHALL be accepted no earlier than 1 cycle after the OUT handshake.
REQ-030 The intermediate carries in P1 and P2 cannot both be 1; no overflow beyond 13 bits SHALL occur.

Reset
REQ-031 rst_n=0 at an edge SHALL, in any state, force: state=IDLE, cin_r=0, op_a=op_b=0, last_r=0, sum_r=0, out_valid=0, add_ins=0.
REQ-032 The cycle after reset, in_ready SHALL be 1.
REQ-033 A limb in flight when reset is applied SHALL be discarded with no output.

Verification
REQ-034 Single limb: a=0xFFF, b=0x001, last=1 -> out_sum=0x000, out_carry=1, out_last=1; out_valid 2 cycles after accept; next limb sees cin_r=0.
REQ-035 Two limbs: (0xFFF,0x001,last=0) then (0x000,0x000,last=1) -> limb0 sum 0x000 carry 1; limb1 takes the P2 path, giving sum 0x001, carry 0, valid 3 cycles after accept.
REQ-036 Carry ripple: cin_r=1, limb (0xFFF,0x000,last=1) -> P1 sum 0xFFF c0; P2 gives out_sum 0x000, out_carry=1.
REQ-037 Interleave: a=0xAAA, b=0x555 in P1 -> add_ins=24'h666666; add_outs=0x0FFF captured as out_sum=0xFFF, out_carry=0.
REQ-038 Backpressure: out_ready=0 for 5 cycles in OUT -> out_* stable, in_ready=0, in_valid ignored; IDLE 1 cycle after out_ready=1.
REQ-039 Reset mid-P2 -> next cycle out_valid=0, add_ins=0, in_ready=1; subsequent (0x001,0x001,last=1) -> sum 0x002, carry 0.

Source files
------------

// File: rtl/bk_limb_add_ctrl.sv
// Sequencer for multi-limb addition over an external 12-bit adder with bit-interleaved inputs.
// Each limb takes one adder pass, plus a second +1 pass when the previous limb carried out.
module bk_limb_add_ctrl #(
  parameter int unsigned LIMB_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LIMB_W-1:0]     in_a,
  input  logic [LIMB_W-1:0]     in_b,
  input  logic                  in_last,
  output logic [2*LIMB_W-1:0]   add_ins,
  input  logic [LIMB_W:0]       add_outs,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LIMB_W-1:0]     out_sum,
  output logic                  out_carry,
  output logic                  out_last
);

  typedef enum logic [1:0] {StIdle, StP1, StP2, StOut} state_e;

  localparam logic [LIMB_W-1:0] One = {{(LIMB_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic                cin_q;
  logic [LIMB_W-1:0]   op_a_q;
  logic [LIMB_W-1:0]   op_b_q;
  logic                last_q;
  logic [LIMB_W:0]     sum_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [LIMB_W-1:0]   out_sum_q;
  logic                out_carry_q;
  logic                out_last_q;

  // The adder expects X and Y bit-interleaved: bit 2i is X[i], bit 2i+1 is Y[i].
  function automatic logic [2*LIMB_W-1:0] interleave(input logic [LIMB_W-1:0] x,
                                                     input logic [LIMB_W-1:0] y);
    logic [2*LIMB_W-1:0] r;
    for (int i = 0; i < int'(LIMB_W); i++) begin
      r[2*i]   = x[i];
      r[2*i+1] = y[i];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cin_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      last_q      <= 1'b0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_a_q     <= in_a;
            op_b_q     <= in_b;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            state_q    <= StP1;
          end
        end
        StP1: begin
          sum_q <= add_outs;
          if (cin_q) begin
            state_q <= StP2;
          end else begin
            out_valid_q <= 1'b1;
            out_sum_q   <= add_outs[LIMB_W-1:0];
            out_carry_q <= add_outs[LIMB_W];
            out_last_q  <= last_q;
            state_q     <= StOut;
          end
        end
        StP2: begin
          // At most one of the two passes can carry out, so OR-ing them cannot lose a bit.
          sum_q       <= {sum_q[LIMB_W] | add_outs[LIMB_W], add_outs[LIMB_W-1:0]};
          out_valid_q <= 1'b1;
          out_sum_q   <= add_outs[LIMB_W-1:0];
          out_carry_q <= sum_q[LIMB_W] | add_outs[LIMB_W];
          out_last_q  <= last_q;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            cin_q       <= last_q ? 1'b0 : sum_q[LIMB_W];
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    add_ins = '0;
    unique case (state_q)
      StP1:    add_ins = interleave(op_a_q, op_b_q);
      StP2:    add_ins = interleave(sum_q[LIMB_W-1:0], One);
      default: add_ins = '0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bk_limb_add_ctrl.sv
// Self-checking bench for bk_limb_add_ctrl: behavioural adder on add_ins/add_outs and an
// arithmetic reference model (limb sum plus carry-in from the previous non-last limb).
module tb_bk_limb_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        in_last;
  logic [23:0] add_ins;
  logic [12:0] add_outs;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_carry;
  logic        out_last;

  int   checks   = 0;
  int   failures = 0;
  logic cin_m    = 1'b0;

  always #5 clk = ~clk;

  bk_limb_add_ctrl #(.LIMB_W(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .add_ins  (add_ins),
    .add_outs (add_outs),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_last (out_last)
  );

  // External adder: de-interleave X/Y and add.
  always_comb begin
    logic [11:0] x;
    logic [11:0] y;
    x = '0;
    y = '0;
    for (int i = 0; i < 12; i++) begin
      x[i] = add_ins[2*i];
      y[i] = add_ins[2*i+1];
    end
    add_outs = {1'b0, x} + {1'b0, y};
  end

  function automatic logic [23:0] ilv(input logic [11:0] x, input logic [11:0] y);
    logic [23:0] r;
    for (int i = 0; i < 12; i++) begin
      r[2*i]   = x[i];
      r[2*i+1] = y[i];
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cin_m = 1'b0;
  endtask

  // Present one limb, wait for its result, optionally stall the consumer, then hand it off.
  task automatic send_limb(input logic [11:0] a, input logic [11:0] b, input logic last,
                           input int bp);
    logic [12:0] exp_sum;
    logic [11:0] held_sum;
    int          n;
    exp_sum  = {1'b0, a} + {1'b0, b} + {12'd0, cin_m};
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 12'($urandom);
    in_b     = 12'($urandom);
    check_eq("add_ins_p1", {8'd0, add_ins}, {8'd0, ilv(a, b)});
    check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    // Edges after the accept edge; the accept cycle itself is cycle 0 of the latency count.
    check_eq("latency_edges", n, cin_m ? 32'd2 : 32'd1);
    check_eq("out_sum", {20'd0, out_sum}, {20'd0, exp_sum[11:0]});
    check_eq("out_carry", {31'd0, out_carry}, {31'd0, exp_sum[12]});
    check_eq("out_last", {31'd0, out_last}, {31'd0, last});
    check_eq("add_ins_out", {8'd0, add_ins}, 32'd0);
    held_sum = out_sum;
    for (int k = 0; k < bp; k++) begin
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_sum", {20'd0, out_sum}, {20'd0, held_sum});
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("idle_out_sum", {20'd0, out_sum}, 32'd0);
    cin_m = last ? 1'b0 : exp_sum[12];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_add_ins", {8'd0, add_ins}, 32'd0);
    check_eq("rst_out_sum", {20'd0, out_sum}, 32'd0);

    send_limb(12'hFFF, 12'h001, 1'b1, 0);
    send_limb(12'hFFF, 12'h001, 1'b0, 0);
    send_limb(12'h000, 12'h000, 1'b1, 0);
    send_limb(12'hFFF, 12'h001, 1'b0, 0);
    send_limb(12'hFFF, 12'h000, 1'b1, 0);
    send_limb(12'hAAA, 12'h555, 1'b1, 0);
    check_eq("ilv_pattern", {8'd0, ilv(12'hAAA, 12'h555)}, 32'h00666666);
    send_limb(12'h123, 12'h456, 1'b0, 5);

    // Reset while the second (+1) pass is in flight.
    send_limb(12'hFFF, 12'h001, 1'b0, 0);
    in_a     = 12'h005;
    in_b     = 12'h006;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("add_ins_p2", {8'd0, add_ins}, {8'd0, ilv(12'h00B, 12'h001)});
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cin_m = 1'b0;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_add_ins", {8'd0, add_ins}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    send_limb(12'h001, 12'h001, 1'b1, 0);

    for (int t = 0; t < 40; t++) begin
      send_limb(12'($urandom), 12'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, 2));
    end
    for (int t = 0; t < 10; t++) begin
      send_limb(12'hFFF, 12'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
